// File: rtl/mode_key_conditioner.sv
`default_nettype none
// ============================================================================
// mode_key_conditioner : synchronise, debounce and press-detect the mode and
// clear buttons; latch a one-hot mode code for the mode state machine.
// Revision 1.0
// ============================================================================
module mode_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_mode,
    input  logic       btn_clr,
    output logic [2:0] mode_out,
    output logic       mode_chg,
    output logic [3:0] key_level
);

    localparam int               c_NUM_CH  = 4;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_NUM_CH-1:0] w_raw;
    logic [c_NUM_CH-1:0] r_sync1;
    logic [c_NUM_CH-1:0] r_sync2;
    logic [c_NUM_CH-1:0] w_stable;
    logic [c_NUM_CH-1:0] r_stable_d;
    logic [c_NUM_CH-1:0] w_press;
    logic [2:0]          r_mode;
    logic [2:0]          w_mode_next;
    logic                r_mode_chg;

    assign w_raw = {btn_clr, btn_mode};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to the accepted level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
    generate
        for (genvar i = 0; i < c_NUM_CH; i++) begin : g_chan
            logic [CNT_W-1:0] r_cnt;
            logic             r_stable;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync2[i] != r_stable) begin
                    if (r_cnt == c_CNT_MAX) begin
                        r_stable <= r_sync2[i];
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_stable[i] = r_stable;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    assign w_press = w_stable & ~r_stable_d;

    // Clear wins; simultaneous mode presses are ambiguous and select nothing.
    always_comb begin
        w_mode_next = r_mode;
        if (w_press[3]) begin
            w_mode_next = 3'b000;
        end else begin
            case (w_press[2:0])
                3'b000:  w_mode_next = r_mode;
                3'b001,
                3'b010,
                3'b100:  w_mode_next = w_press[2:0];
                default: w_mode_next = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= 3'b000;
            r_mode_chg <= 1'b0;
        end else begin
            r_mode     <= w_mode_next;
            r_mode_chg <= (w_mode_next != r_mode);
        end
    end

    assign mode_out  = r_mode;
    assign mode_chg  = r_mode_chg;
    assign key_level = w_stable;

endmodule
`default_nettype wire
